hls_ap_seq: RTL and testbench
=============================

# hls_ap_seq

Sequencer for a Vivado-HLS block using the ap_ctrl_hs handshake. It runs the post-reset flush, then executes host-requested runs of N iterations, and detects a stalled core and recovers it. It sits between the FrontPanel wire/trigger endpoints and the HLS core, beside the input mux and the output FIFO. It replaces ad-hoc glue FSMs in top levels.

## Interface
- CNT_W, 11: width of iteration counters; max run length 2^CNT_W-1.
- RST_CYCLES, 4: cycles hls_rst is held in S_RESET (≥1).
- FLUSH_CNT, 20: ap_ready handshakes consumed by the zero-stimulus flush (≥1).
- WDOG_W, 16: watchdog width; timeout at 2^WDOG_W-1 cycles without progress.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous, active-high; level-held behaves as repeated abort.
- start  in  1  single-cycle run request.
- abort  in  1  single-cycle cancel.
- num_iter  in  CNT_W  iterations per run; sampled on accepted start.
- hls_ap_ready, hls_ap_done, hls_ap_idle  in  1  core handshake.
- hls_ap_start  out  1  core start.
- hls_rst  out  1  active-high core reset; top drives core ap_rst_n = ~hls_rst.
- flush_active  out  1  top muxes zero data with valid=1 into core input.
- fifo_out_rst  out  1  one-cycle output-FIFO sync reset.
- idle  out  1  state == S_IDLE.
- done_sticky  out  1  set on run completion; cleared by accepted start or soft_reset.
- timeout_sticky  out  1  set on watchdog expiry; cleared by soft_reset only.
- iter_count  out  CNT_W  ap_ready count of the current or last run.

## Operation
- States: S_RESET, S_FLUSH, S_IDLE, S_RUN, S_DRAIN. Registered state; all outputs are registered or a pure state decode.
- S_RESET: hls_rst=1. After RST_CYCLES cycles, go to S_FLUSH.
- S_FLUSH: hls_ap_start=1 and flush_active=1. Count hls_ap_ready. On the ready that makes the count equal FLUSH_CNT, go to S_IDLE and pulse fifo_out_rst in the first S_IDLE cycle.
- S_IDLE: a start pulse is accepted here only. It latches num_iter, clears iter_count and done_sticky, then:
  - num_iter==0: stay in S_IDLE and set done_sticky with no core activity.
  - otherwise: go to S_RUN.
- S_RUN: hls_ap_start=1. Each hls_ap_ready increments iter_count. On the ready where iter_count+1 == latched num_iter, go to S_DRAIN. hls_ap_start is low the next cycle, so no extra iteration starts.
- S_DRAIN: on hls_ap_done or hls_ap_idle, go to S_IDLE and set done_sticky.
- Watchdog runs in S_RUN, S_FLUSH and S_DRAIN:
  - clears on any hls_ap_ready, hls_ap_done or state entry;
  - at saturation, set timeout_sticky and go to S_RESET.
- abort: from S_RUN, S_DRAIN or S_FLUSH, go to S_RESET. Ignored in S_IDLE and S_RESET. done_sticky is not set.
- soft_reset: go to S_RESET from any state and clear both sticky flags and iter_count.
- Priority per cycle: soft_reset > abort > watchdog > start/handshake.
- start outside S_IDLE is dropped (no queueing).
- hls_ap_ready outside S_RUN/S_FLUSH is ignored.

## Timing
- Async reset values: state=S_RESET, hls_rst=1, hls_ap_start=0, flush_active=0, fifo_out_rst=0, idle=0, both stickies=0, iter_count=0, watchdog=0, reset counter=0.
- Reset deassertion to first hls_ap_start: RST_CYCLES+1 cycles.
- start in cycle t gives hls_ap_start=1 in t+1.
- Final ready in cycle t gives hls_ap_start=0 in t+1.
- ap_done in cycle t gives idle=1 and done_sticky=1 in t+1.
- iter_count updates one cycle after the ready. It never exceeds num_iter and never wraps.

## Structure
- Shared package hls_ctrl_pkg holds the state encoding and default values of CNT_W, FLUSH_CNT and WDOG_W; top levels reference it.
- One sub-module, hls_wdog: a saturating counter with clear/enable inputs and an expired output. Reused for other endpoint timeouts.

## Test plan
- Reset release, core acks a ready every 3 cycles -> hls_rst high 4 cycles, exactly 20 flush readies, one fifo_out_rst pulse, idle=1.
- start with num_iter=5, then ap_done -> exactly 5 ready handshakes, hls_ap_start low the cycle after the 5th, iter_count=5, done_sticky=1.
- start with num_iter=0 -> hls_ap_start never rises, done_sticky=1 next cycle.
- abort after the 2nd ready of a 10-iteration run -> S_RESET, hls_rst=1, reflush, done_sticky=0.
- Core never asserts ready in S_RUN (WDOG_W=4) -> timeout_sticky=1 after 15 cycles, core reset and reflushed; soft_reset clears the flag.
- start and abort in the same cycle during S_RUN, and start during S_DRAIN -> abort wins and the start is dropped with no extra run.

Source files
------------

// File: rtl/hls_ctrl_pkg.sv
// Shared definitions for HLS ap_ctrl_hs sequencers: state encoding and
// default sizing of iteration counters, flush length and watchdog.
package hls_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FLUSH = 3'd1,
    S_IDLE  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } hls_state_e;

  localparam int CNT_W_DEF      = 11;
  localparam int RST_CYCLES_DEF = 4;
  localparam int FLUSH_CNT_DEF  = 20;
  localparam int WDOG_W_DEF     = 16;

endpackage

// File: rtl/hls_wdog.sv
// Saturating progress watchdog: counts enabled cycles since the last clear
// and flags expiry once the counter reaches all-ones.
module hls_wdog #(
  parameter int WDOG_W = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WDOG_W-1:0] MAX = '1;

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == MAX);

endmodule

// File: rtl/hls_ap_seq.sv
// Sequencer for an ap_ctrl_hs HLS core: post-reset flush, host-requested
// N-iteration runs, abort handling and stall recovery via a watchdog.
module hls_ap_seq
  import hls_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int FLUSH_CNT  = FLUSH_CNT_DEF,
  parameter int WDOG_W     = WDOG_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             soft_reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_iter,
  input  logic             hls_ap_ready,
  input  logic             hls_ap_done,
  input  logic             hls_ap_idle,
  output logic             hls_ap_start,
  output logic             hls_rst,
  output logic             flush_active,
  output logic             fifo_out_rst,
  output logic             idle,
  output logic             done_sticky,
  output logic             timeout_sticky,
  output logic [CNT_W-1:0] iter_count
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int FL_W = $clog2(FLUSH_CNT + 1);

  hls_state_e       state_q, state_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             fifo_q, fifo_d;
  logic             wd_en, wd_clr, wd_exp;
  logic             abortable;

  assign wd_en     = (state_q == S_FLUSH) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign abortable = wd_en;
  assign wd_clr    = !wd_en || (state_d != state_q) || hls_ap_ready || hls_ap_done;

  hls_wdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk_i     (ap_clk),
    .rst_ni    (ap_rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_exp)
  );

  always_comb begin
    state_d = state_q;
    rc_d    = '0;
    fl_d    = '0;
    iter_d  = iter_q;
    num_d   = num_q;
    done_d  = done_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_RESET: begin
        if (rc_q == RC_W'(RST_CYCLES - 1)) begin
          state_d = S_FLUSH;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      S_FLUSH: begin
        fl_d = fl_q;
        if (hls_ap_ready) begin
          if (fl_q == FL_W'(FLUSH_CNT - 1)) begin
            state_d = S_IDLE;
          end else begin
            fl_d = fl_q + FL_W'(1);
          end
        end
      end
      S_IDLE: begin
        if (start) begin
          num_d  = num_iter;
          iter_d = '0;
          done_d = (num_iter == '0);
          if (num_iter != '0) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (hls_ap_ready) begin
          iter_d = iter_q + CNT_W'(1);
          // Leaving RUN here drops hls_ap_start before a further iteration can launch.
          if ((iter_q + CNT_W'(1)) == num_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (hls_ap_done || hls_ap_idle) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_RESET;
    endcase

    // Overrides in ascending priority: watchdog, abort, soft reset.
    if (wd_en && wd_exp) begin
      state_d = S_RESET;
      iter_d  = iter_q;
      done_d  = done_q;
      tmo_d   = 1'b1;
    end
    if (abortable && abort) begin
      state_d = S_RESET;
      iter_d  = iter_q;
      done_d  = done_q;
      tmo_d   = tmo_q;
    end
    if (soft_reset) begin
      state_d = S_RESET;
      rc_d    = '0;
      iter_d  = '0;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
    end
  end

  assign fifo_d = (state_q == S_FLUSH) && (state_d == S_IDLE);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_RESET;
      rc_q    <= '0;
      fl_q    <= '0;
      iter_q  <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fifo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      fl_q    <= fl_d;
      iter_q  <= iter_d;
      num_q   <= num_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      fifo_q  <= fifo_d;
    end
  end

  assign hls_rst        = (state_q == S_RESET);
  assign hls_ap_start   = (state_q == S_FLUSH) || (state_q == S_RUN);
  assign flush_active   = (state_q == S_FLUSH);
  assign idle           = (state_q == S_IDLE);
  assign fifo_out_rst   = fifo_q;
  assign done_sticky    = done_q;
  assign timeout_sticky = tmo_q;
  assign iter_count     = iter_q;

endmodule

// File: tb/tb_hls_ap_seq.sv
// Directed bench for hls_ap_seq: table of run lengths plus hand-written
// abort, watchdog, soft-reset and dropped-start sequences.
module tb_hls_ap_seq;

  localparam int CNT_W      = 11;
  localparam int RST_CYCLES = 4;
  localparam int FLUSH_CNT  = 20;
  localparam int WDOG_W     = 4;

  logic             ap_clk;
  logic             ap_rst_n;
  logic             soft_reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_iter;
  logic             hls_ap_ready;
  logic             hls_ap_done;
  logic             hls_ap_idle;
  logic             hls_ap_start;
  logic             hls_rst;
  logic             flush_active;
  logic             fifo_out_rst;
  logic             idle;
  logic             done_sticky;
  logic             timeout_sticky;
  logic [CNT_W-1:0] iter_count;

  hls_ap_seq #(
    .CNT_W      (CNT_W),
    .RST_CYCLES (RST_CYCLES),
    .FLUSH_CNT  (FLUSH_CNT),
    .WDOG_W     (WDOG_W)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .soft_reset     (soft_reset),
    .start          (start),
    .abort          (abort),
    .num_iter       (num_iter),
    .hls_ap_ready   (hls_ap_ready),
    .hls_ap_done    (hls_ap_done),
    .hls_ap_idle    (hls_ap_idle),
    .hls_ap_start   (hls_ap_start),
    .hls_rst        (hls_rst),
    .flush_active   (flush_active),
    .fifo_out_rst   (fifo_out_rst),
    .idle           (idle),
    .done_sticky    (done_sticky),
    .timeout_sticky (timeout_sticky),
    .iter_count     (iter_count)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  typedef struct {
    int n;
    int exp_rdy;
    int exp_iter;
  } vec_t;

  vec_t vecs[5];

  int n_cmp = 0;
  int n_err = 0;
  int auto_en = 1;
  int ph = 0;
  int rdy_prev = 0;
  int flush_rdy = 0;
  int run_rdy = 0;
  int fifo_cnt = 0;
  int rst_hi = 0;
  int start_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock: advance past the edge, update monitors, then present the
  // core's ready for the coming cycle (one handshake every third start cycle).
  task automatic cyc();
    @(posedge ap_clk);
    #1;
    rdy_prev = hls_ap_ready ? 1 : 0;
    if (fifo_out_rst) fifo_cnt++;
    if (hls_rst) rst_hi++;
    if (hls_ap_start) start_seen++;
    hls_ap_ready = (auto_en != 0) && hls_ap_start && (ph == 2);
    ph = hls_ap_start ? (ph + 1) % 3 : 0;
    if (hls_ap_ready) begin
      if (flush_active) flush_rdy++;
      else run_rdy++;
    end
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int k;
    k = 0;
    while (!idle && k < lim) begin
      cyc();
      k++;
    end
    chk({nm, "_idle"}, idle, 1);
    chk({nm, "_fifo_first_idle"}, fifo_out_rst, 1);
  endtask

  task automatic reflush(input string nm);
    flush_rdy = 0;
    fifo_cnt  = 0;
    wait_idle(nm, 200);
    chk({nm, "_flush_rdy"}, flush_rdy, FLUSH_CNT);
    cyc();
    chk({nm, "_fifo_pulses"}, fifo_cnt, 1);
    chk({nm, "_fifo_low"}, fifo_out_rst, 0);
  endtask

  task automatic run_vec(input int idx, input int n, input int exp_rdy, input int exp_iter);
    int k;
    string tag;
    tag = $sformatf("vec%0d", idx);
    run_rdy = 0;
    num_iter = n[CNT_W-1:0];
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk({tag, "_start_lat"}, hls_ap_start, (n != 0) ? 1 : 0);
    if (n == 0) begin
      chk({tag, "_done_now"}, done_sticky, 1);
      chk({tag, "_idle_now"}, idle, 1);
      start_seen = 0;
      for (int i = 0; i < 5; i++) cyc();
      chk({tag, "_no_start"}, start_seen, 0);
      chk({tag, "_iter"}, iter_count, exp_iter);
    end else begin
      chk({tag, "_done_clr"}, done_sticky, 0);
      k = 0;
      while (hls_ap_start && k < 3 * n + 20) begin
        cyc();
        k++;
      end
      chk({tag, "_start_fell"}, hls_ap_start, 0);
      chk({tag, "_ready_before_fall"}, rdy_prev, 1);
      chk({tag, "_readies"}, run_rdy, exp_rdy);
      chk({tag, "_iter_drain"}, iter_count, exp_iter);
      chk({tag, "_not_idle"}, idle, 0);
      hls_ap_done = 1'b1;
      cyc();
      hls_ap_done = 1'b0;
      chk({tag, "_idle"}, idle, 1);
      chk({tag, "_done"}, done_sticky, 1);
      chk({tag, "_iter"}, iter_count, exp_iter);
    end
  endtask

  initial begin
    int k;
    vecs[0] = '{n: 5,    exp_rdy: 5,    exp_iter: 5};
    vecs[1] = '{n: 1,    exp_rdy: 1,    exp_iter: 1};
    vecs[2] = '{n: 0,    exp_rdy: 0,    exp_iter: 0};
    vecs[3] = '{n: 3,    exp_rdy: 3,    exp_iter: 3};
    vecs[4] = '{n: 2047, exp_rdy: 2047, exp_iter: 2047};

    ap_rst_n     = 1'b0;
    soft_reset   = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    num_iter     = '0;
    hls_ap_ready = 1'b0;
    hls_ap_done  = 1'b0;
    hls_ap_idle  = 1'b0;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_hls_rst", hls_rst, 1);
    chk("rst_ap_start", hls_ap_start, 0);
    chk("rst_flush", flush_active, 0);
    chk("rst_fifo", fifo_out_rst, 0);
    chk("rst_idle", idle, 0);
    chk("rst_done", done_sticky, 0);
    chk("rst_tmo", timeout_sticky, 0);
    chk("rst_iter", iter_count, 0);

    // Release reset and measure how long the core is held in reset.
    ap_rst_n = 1'b1;
    rst_hi = hls_rst ? 1 : 0;
    flush_rdy = 0;
    fifo_cnt = 0;
    k = 0;
    while (!hls_ap_start && k < 20) begin
      cyc();
      k++;
    end
    chk("boot_rst_cycles", rst_hi, RST_CYCLES);
    chk("boot_core_rst_off", hls_rst, 0);
    chk("boot_flush_active", flush_active, 1);
    wait_idle("boot", 200);
    chk("boot_flush_rdy", flush_rdy, FLUSH_CNT);
    cyc();
    chk("boot_fifo_pulses", fifo_cnt, 1);
    chk("boot_fifo_low", fifo_out_rst, 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(i, vecs[i].n, vecs[i].exp_rdy, vecs[i].exp_iter);
    end

    // Abort after the second ready of a 10-iteration run.
    run_rdy = 0;
    num_iter = 11'd10;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (run_rdy < 2 && k < 30) begin
      cyc();
      k++;
    end
    cyc();
    chk("abort_iter_before", iter_count, 2);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_hls_rst", hls_rst, 1);
    chk("abort_start_low", hls_ap_start, 0);
    chk("abort_done", done_sticky, 0);
    chk("abort_tmo", timeout_sticky, 0);
    reflush("abort");
    chk("abort_done_after", done_sticky, 0);

    // Stalled core: no readies in RUN until the watchdog fires.
    auto_en = 0;
    num_iter = 11'd4;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (!timeout_sticky && k < 40) begin
      cyc();
      k++;
    end
    chk("wdog_cycles", k, 16);
    chk("wdog_tmo", timeout_sticky, 1);
    chk("wdog_hls_rst", hls_rst, 1);
    auto_en = 1;
    reflush("wdog");
    chk("wdog_tmo_held", timeout_sticky, 1);
    soft_reset = 1'b1;
    cyc();
    soft_reset = 1'b0;
    chk("srst_tmo", timeout_sticky, 0);
    chk("srst_hls_rst", hls_rst, 1);
    chk("srst_iter", iter_count, 0);
    chk("srst_done", done_sticky, 0);
    reflush("srst");

    // start together with abort during RUN: abort wins, start is dropped.
    run_rdy = 0;
    num_iter = 11'd6;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (run_rdy < 1 && k < 30) begin
      cyc();
      k++;
    end
    cyc();
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_hls_rst", hls_rst, 1);
    chk("sa_idle", idle, 0);
    reflush("sa");
    start_seen = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("sa_no_extra_run", start_seen, 0);
    chk("sa_still_idle", idle, 1);

    // start during DRAIN is dropped.
    run_rdy = 0;
    num_iter = 11'd2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (hls_ap_start && k < 30) begin
      cyc();
      k++;
    end
    num_iter = 11'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("drain_start_dropped", hls_ap_start, 0);
    chk("drain_still_busy", idle, 0);
    hls_ap_idle = 1'b1;
    cyc();
    hls_ap_idle = 1'b0;
    chk("drain_idle", idle, 1);
    chk("drain_done", done_sticky, 1);
    chk("drain_iter", iter_count, 2);
    start_seen = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("drain_no_extra_run", start_seen, 0);
    chk("drain_readies", run_rdy, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
